// File: rtl/machine_csr_file_if.sv
// ---------------------------------------------------------------------------
// machine_csr_file_if
// CSR access bus between the pipeline (master) and the machine CSR file
// (slave). The signal names keep their _in/_out suffixes so they match the
// CSR file's documented pin names.
//   csr_addr_in     [11:0]  CSR address
//   csr_op_in       [1:0]   00 none, 01 RW, 10 RS (set), 11 RC (clear)
//   csr_wdata_in    [31:0]  operand (rs1 value or zero-extended zimm)
//   csr_data_out    [31:0]  pre-update value of the addressed CSR
//   illegal_csr_out         access fault for the current request
// ---------------------------------------------------------------------------
interface machine_csr_file_if;
  logic [11:0] csr_addr_in;
  logic [1:0]  csr_op_in;
  logic [31:0] csr_wdata_in;
  logic [31:0] csr_data_out;
  logic        illegal_csr_out;

  modport master (
    output csr_addr_in,
    output csr_op_in,
    output csr_wdata_in,
    input  csr_data_out,
    input  illegal_csr_out
  );

  modport slave (
    input  csr_addr_in,
    input  csr_op_in,
    input  csr_wdata_in,
    output csr_data_out,
    output illegal_csr_out
  );
endinterface

// File: rtl/machine_csr_file.sv
// ---------------------------------------------------------------------------
// machine_csr_file
// Machine-mode CSR file for a single-hart RV32 core: mstatus, misa, mie,
// mtvec, mscratch, mepc, mcause, mip, 64-bit mcycle/minstret plus the
// read-only ID registers and user counter shadows.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   csr_bus (slave)           CSR read/modify/write access + fault flag
//   set_epc_in, pc_in         capture trapping PC into mepc
//   set_cause_in, i_or_e_in,
//   cause_in                  capture trap cause into mcause
//   mie_clear_in, mie_set_in  trap entry / trap return MIE stacking
//   instruct_inc_in           instruction retired (minstret increment)
//   eirq_in, tirq_in          external / timer interrupt levels
//   mie_out, meie_out, mtie_out, msie_out,
//   meip_out, mtip_out, msip_out   interrupt state bits
//   trap_addr_out             trap vector target
//   epc_out                   current mepc
// ---------------------------------------------------------------------------
module machine_csr_file (
  input  logic        clk_in,
  input  logic        rst_in,
  machine_csr_file_if.slave csr_bus,
  input  logic        set_epc_in,
  input  logic [31:0] pc_in,
  input  logic        set_cause_in,
  input  logic        i_or_e_in,
  input  logic [3:0]  cause_in,
  input  logic        mie_clear_in,
  input  logic        mie_set_in,
  input  logic        instruct_inc_in,
  input  logic        eirq_in,
  input  logic        tirq_in,
  output logic        mie_out,
  output logic        meie_out,
  output logic        mtie_out,
  output logic        msie_out,
  output logic        meip_out,
  output logic        mtip_out,
  output logic        msip_out,
  output logic [31:0] trap_addr_out,
  output logic [31:0] epc_out
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;  // RV32, I extension

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // Architectural state
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic        meie_reg;
  logic        mtie_reg;
  logic        msie_reg;
  logic        meip_reg;
  logic        mtip_reg;
  logic        msip_reg;
  logic [29:0] mtvec_base_reg;
  logic        mtvec_mode_reg;
  logic [31:0] mscratch_reg;
  logic [29:0] mepc_reg;
  logic        mcause_irq_reg;
  logic [3:0]  mcause_code_reg;
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  // Access decode
  logic [31:0] read_data;
  logic        implemented;
  logic        read_only;
  logic        illegal;
  logic        write_en;
  logic [31:0] write_value;

  logic [11:0] addr;
  logic [1:0]  op;
  logic [31:0] wdata;

  assign addr  = csr_bus.csr_addr_in;
  assign op    = csr_bus.csr_op_in;
  assign wdata = csr_bus.csr_wdata_in;

  // pc_in[1:0] is dropped on capture because mepc is always word aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_in[1:0];

  always_comb begin
    read_data   = 32'h0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (addr)
      ADDR_MSTATUS:   read_data = {19'h0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
      ADDR_MISA: begin
        read_data = MISA_VALUE;
        read_only = 1'b1;
      end
      ADDR_MIE:       read_data = {20'h0, meie_reg, 3'b0, mtie_reg, 3'b0, msie_reg, 3'b0};
      ADDR_MTVEC:     read_data = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
      ADDR_MSCRATCH:  read_data = mscratch_reg;
      ADDR_MEPC:      read_data = {mepc_reg, 2'b00};
      ADDR_MCAUSE:    read_data = {mcause_irq_reg, 27'h0, mcause_code_reg};
      ADDR_MIP:       read_data = {20'h0, meip_reg, 3'b0, mtip_reg, 3'b0, msip_reg, 3'b0};
      ADDR_MCYCLE:    read_data = mcycle_reg[31:0];
      ADDR_MINSTRET:  read_data = minstret_reg[31:0];
      ADDR_MCYCLEH:   read_data = mcycle_reg[63:32];
      ADDR_MINSTRETH: read_data = minstret_reg[63:32];
      ADDR_CYCLE: begin
        read_data = mcycle_reg[31:0];
        read_only = 1'b1;
      end
      ADDR_INSTRET: begin
        read_data = minstret_reg[31:0];
        read_only = 1'b1;
      end
      ADDR_CYCLEH: begin
        read_data = mcycle_reg[63:32];
        read_only = 1'b1;
      end
      ADDR_INSTRETH: begin
        read_data = minstret_reg[63:32];
        read_only = 1'b1;
      end
      ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MHARTID: read_only = 1'b1;
      default:        implemented = 1'b0;
    endcase
  end

  // A read-only CSR may still be read through RS/RC with a zero operand.
  assign illegal = (op != OP_NONE) &&
                   (!implemented || (read_only && ((op == OP_RW) || (wdata != 32'h0))));

  // RS/RC with a zero operand is a pure read and must not disturb the
  // counters (it would otherwise freeze their increment for a cycle).
  assign write_en = (op != OP_NONE) && !illegal && ((op == OP_RW) || (wdata != 32'h0));

  always_comb begin
    case (op)
      OP_RW:   write_value = wdata;
      OP_RS:   write_value = read_data | wdata;
      OP_RC:   write_value = read_data & ~wdata;
      default: write_value = read_data;
    endcase
  end

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mip;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign wr_mstatus   = write_en && (addr == ADDR_MSTATUS);
  assign wr_mie       = write_en && (addr == ADDR_MIE);
  assign wr_mtvec     = write_en && (addr == ADDR_MTVEC);
  assign wr_mscratch  = write_en && (addr == ADDR_MSCRATCH);
  assign wr_mepc      = write_en && (addr == ADDR_MEPC);
  assign wr_mcause    = write_en && (addr == ADDR_MCAUSE);
  assign wr_mip       = write_en && (addr == ADDR_MIP);
  assign wr_mcycle    = write_en && (addr == ADDR_MCYCLE);
  assign wr_mcycleh   = write_en && (addr == ADDR_MCYCLEH);
  assign wr_minstret  = write_en && (addr == ADDR_MINSTRET);
  assign wr_minstreth = write_en && (addr == ADDR_MINSTRETH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      meie_reg         <= 1'b0;
      mtie_reg         <= 1'b0;
      msie_reg         <= 1'b0;
      meip_reg         <= 1'b0;
      mtip_reg         <= 1'b0;
      msip_reg         <= 1'b0;
      mtvec_base_reg   <= 30'h0;
      mtvec_mode_reg   <= 1'b0;
      mscratch_reg     <= 32'h0;
      mepc_reg         <= 30'h0;
      mcause_irq_reg   <= 1'b0;
      mcause_code_reg  <= 4'h0;
      mcycle_reg       <= 64'h0;
      minstret_reg     <= 64'h0;
    end else begin
      // Trap entry beats trap return, and both beat a software write.
      if (mie_clear_in) begin
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mie_set_in) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (wr_mstatus) begin
        mstatus_mie_reg  <= write_value[3];
        mstatus_mpie_reg <= write_value[7];
      end

      if (wr_mie) begin
        meie_reg <= write_value[11];
        mtie_reg <= write_value[7];
        msie_reg <= write_value[3];
      end

      // Pending bits for external/timer follow the pins, one cycle late.
      meip_reg <= eirq_in;
      mtip_reg <= tirq_in;
      if (wr_mip) begin
        msip_reg <= write_value[3];
      end

      if (wr_mtvec) begin
        mtvec_base_reg <= write_value[31:2];
        mtvec_mode_reg <= write_value[0];
      end

      if (wr_mscratch) begin
        mscratch_reg <= write_value;
      end

      if (set_epc_in) begin
        mepc_reg <= pc_in[31:2];
      end else if (wr_mepc) begin
        mepc_reg <= write_value[31:2];
      end

      if (set_cause_in) begin
        mcause_irq_reg  <= i_or_e_in;
        mcause_code_reg <= cause_in;
      end else if (wr_mcause) begin
        mcause_irq_reg  <= write_value[31];
        mcause_code_reg <= write_value[3:0];
      end

      // A write to either half replaces the increment for that cycle.
      if (wr_mcycle) begin
        mcycle_reg[31:0] <= write_value;
      end else if (wr_mcycleh) begin
        mcycle_reg[63:32] <= write_value;
      end else begin
        mcycle_reg <= mcycle_reg + 64'd1;
      end

      if (wr_minstret) begin
        minstret_reg[31:0] <= write_value;
      end else if (wr_minstreth) begin
        minstret_reg[63:32] <= write_value;
      end else if (instruct_inc_in) begin
        minstret_reg <= minstret_reg + 64'd1;
      end
    end
  end

  assign csr_bus.csr_data_out    = read_data;
  assign csr_bus.illegal_csr_out = illegal;

  // Vectored mode only applies to interrupts; exceptions always use the base.
  assign trap_addr_out = (mtvec_mode_reg && i_or_e_in)
                         ? ({mtvec_base_reg, 2'b00} + {26'h0, cause_in, 2'b00})
                         : {mtvec_base_reg, 2'b00};

  assign epc_out  = {mepc_reg, 2'b00};
  assign mie_out  = mstatus_mie_reg;
  assign meie_out = meie_reg;
  assign mtie_out = mtie_reg;
  assign msie_out = msie_reg;
  assign meip_out = meip_reg;
  assign mtip_out = mtip_reg;
  assign msip_out = msip_reg;

endmodule
